// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: M-stage data-memory access controller and MEM/WB register.
// It issues one req/ack access per load/store to a variable-latency memory,
// stalls the front of the pipeline while that access is outstanding, and
// aborts the access if dmem_ack does not arrive within TIMEOUT cycles.
// Optional build macro MEM_ALIGN_CHECK_EN adds the misalign_M output and
// rejects word accesses whose address is not 4-byte aligned.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Mem_Read_M,
  input  logic        Mem_Write_M,
  input  logic        Mem_To_Reg_M,
  input  logic        Reg_Write_M,
  input  logic [31:0] ALU_Result_M,
  input  logic [31:0] Write_Data_M,
  input  logic [4:0]  Write_Reg_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_M,
  output logic        bus_err,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        misalign_M,
`endif
  output logic [31:0] Read_Data_W,
  output logic [31:0] ALU_Result_W,
  output logic [4:0]  Write_Reg_W,
  output logic        Mem_To_Reg_W,
  output logic        Reg_Write_W
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Last counter value before the access is declared lost.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [31:0] cap_q;

  logic access_w;
  logic misalign_w;
  logic start_w;

  assign access_w = Mem_Read_M | Mem_Write_M;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_w = access_w & (ALU_Result_M[1:0] != 2'b00);
  assign misalign_M = (state_q == S_IDLE) & misalign_w;
`else
  assign misalign_w = 1'b0;
`endif

  // A new access is launched only from IDLE and only when it is legal.
  assign start_w = (state_q == S_IDLE) & access_w & ~misalign_w;

  // Hold the front of the pipeline from launch until the access completes;
  // forced low while reset is asserted so upstream stages are never frozen.
  assign stall_M = rst_n & (start_w | (state_q == S_BUSY));

  // Access FSM, memory-port registers and MEM/WB register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cap_q        <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      bus_err      <= 1'b0;
      Read_Data_W  <= '0;
      ALU_Result_W <= '0;
      Write_Reg_W  <= '0;
      Mem_To_Reg_W <= 1'b0;
      Reg_Write_W  <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_w) begin
            // Store wins when both read and write are requested.
            dmem_req     <= 1'b1;
            dmem_we      <= Mem_Write_M;
            dmem_addr    <= ALU_Result_M;
            dmem_wdata   <= Write_Data_M;
            cnt_q        <= '0;
            state_q      <= S_BUSY;
            Reg_Write_W  <= 1'b0;
            Mem_To_Reg_W <= 1'b0;
          end else begin
            // Non-memory op (or rejected misaligned access) passes straight through.
            Read_Data_W  <= '0;
            ALU_Result_W <= ALU_Result_M;
            Write_Reg_W  <= Write_Reg_M;
            Mem_To_Reg_W <= Mem_To_Reg_M;
            Reg_Write_W  <= Reg_Write_M & ~misalign_w;
          end
        end
        S_BUSY: begin
          Reg_Write_W  <= 1'b0;
          Mem_To_Reg_W <= 1'b0;
          if (dmem_ack) begin
            cap_q    <= dmem_we ? 32'd0 : dmem_rdata;
            dmem_req <= 1'b0;
            state_q  <= S_DONE;
          end else if (cnt_q == TO_LAST) begin
            cap_q    <= ERR_DATA;
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DONE: begin
          // The M inputs were held by the stall, so they still describe this access.
          Read_Data_W  <= cap_q;
          ALU_Result_W <= ALU_Result_M;
          Write_Reg_W  <= Write_Reg_M;
          Mem_To_Reg_W <= Mem_To_Reg_M;
          Reg_Write_W  <= Reg_Write_M;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with TIMEOUT=4.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst_n;
  logic        Mem_Read_M, Mem_Write_M, Mem_To_Reg_M, Reg_Write_M;
  logic [31:0] ALU_Result_M, Write_Data_M;
  logic [4:0]  Write_Reg_M;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall_M, bus_err;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_M;
`endif
  logic [31:0] Read_Data_W, ALU_Result_W;
  logic [4:0]  Write_Reg_W;
  logic        Mem_To_Reg_W, Reg_Write_W;

  int n_checks = 0;
  int n_pass   = 0;
  int stall_cnt;
  int req_cnt;
  int early_err;

  mem_stage_ctrl #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .Mem_Read_M(Mem_Read_M), .Mem_Write_M(Mem_Write_M),
    .Mem_To_Reg_M(Mem_To_Reg_M), .Reg_Write_M(Reg_Write_M),
    .ALU_Result_M(ALU_Result_M), .Write_Data_M(Write_Data_M),
    .Write_Reg_M(Write_Reg_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_M(stall_M), .bus_err(bus_err),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign_M(misalign_M),
`endif
    .Read_Data_W(Read_Data_W), .ALU_Result_W(ALU_Result_W),
    .Write_Reg_W(Write_Reg_W), .Mem_To_Reg_W(Mem_To_Reg_W),
    .Reg_Write_W(Reg_Write_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=%h", tag, got);
    end else begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr_reg);
    Mem_Read_M   = rd;
    Mem_Write_M  = wr;
    Mem_To_Reg_M = m2r;
    Reg_Write_M  = rw;
    ALU_Result_M = alu;
    Write_Data_M = wd;
    Write_Reg_M  = wr_reg;
  endtask

  initial begin
    rst_n = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    set_m(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", dmem_req, 0);
    check("rst_stall", stall_M, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_rdw", Read_Data_W, 0);
    check("rst_regw", Reg_Write_W, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU-only op passes straight into MEM/WB.
    set_m(0, 0, 0, 1, 32'h10, 32'h0, 5'd5);
    #1;
    check("alu_stall", stall_M, 0);
    tick();
    check("alu_regw", Reg_Write_W, 1);
    check("alu_wreg", Write_Reg_W, 5);
    check("alu_res", ALU_Result_W, 32'h10);
    check("alu_rdw", Read_Data_W, 0);

    // Load from 0x100, ack on BUSY cycle 3.
    set_m(1, 0, 1, 1, 32'h100, 32'h0, 5'd7);
    #1;
    stall_cnt = 0;
    check("ld_idle_stall", stall_M, 1);
    if (stall_M) stall_cnt++;
    tick();                                   // BUSY 1
    check("ld_req", dmem_req, 1);
    check("ld_we", dmem_we, 0);
    check("ld_addr", dmem_addr, 32'h100);
    check("ld_bubble", Reg_Write_W, 0);
    if (stall_M) stall_cnt++;
    tick();                                   // BUSY 2
    if (stall_M) stall_cnt++;
    tick();                                   // BUSY 3
    check("ld_req_b3", dmem_req, 1);
    if (stall_M) stall_cnt++;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    tick();                                   // DONE
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    if (stall_M) stall_cnt++;
    check("ld_stall_cycles", stall_cnt, 4);
    check("ld_done_req", dmem_req, 0);
    check("ld_done_bubble", Reg_Write_W, 0);
    tick();
    check("ld_rdw", Read_Data_W, 32'hCAFE_F00D);
    check("ld_m2r", Mem_To_Reg_W, 1);
    check("ld_regw", Reg_Write_W, 1);
    check("ld_wreg", Write_Reg_W, 7);

    // Ack while IDLE is ignored.
    set_m(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    tick();
    dmem_ack = 1'b0;
    check("idle_ack_req", dmem_req, 0);
    check("idle_ack_rdw", Read_Data_W, 0);

    // Store 0x12345678 to 0x40, ack on BUSY cycle 1.
    set_m(0, 1, 0, 0, 32'h40, 32'h1234_5678, 5'd3);
    #1;
    stall_cnt = 0;
    req_cnt = 0;
    if (stall_M) stall_cnt++;
    tick();                                   // BUSY 1
    check("st_we", dmem_we, 1);
    check("st_wdata", dmem_wdata, 32'h1234_5678);
    check("st_addr", dmem_addr, 32'h40);
    if (stall_M) stall_cnt++;
    if (dmem_req) req_cnt++;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    tick();                                   // DONE
    dmem_ack = 1'b0;
    if (stall_M) stall_cnt++;
    if (dmem_req) req_cnt++;
    check("st_stall_cycles", stall_cnt, 2);
    check("st_req_cycles", req_cnt, 1);
    tick();
    check("st_rdw", Read_Data_W, 0);
    check("st_regw", Reg_Write_W, 0);
    check("st_alu", ALU_Result_W, 32'h40);
    set_m(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    tick();

    // Load that is never acknowledged: abort after 4 BUSY cycles.
    set_m(1, 0, 1, 1, 32'h200, 32'h0, 5'd9);
    tick();                                   // BUSY 1
    req_cnt = 0;
    early_err = 0;
    while (dmem_req && req_cnt < 20) begin
      if (bus_err) early_err = 1;
      req_cnt++;
      tick();
    end
    check("to_req_cycles", req_cnt, 4);
    check("to_no_early_err", early_err, 0);
    check("to_bus_err", bus_err, 1);
    check("to_stall_done", stall_M, 0);
    tick();
    check("to_bus_err_pulse", bus_err, 0);
    check("to_rdw", Read_Data_W, 32'hDEAD_BEEF);
    check("to_regw", Reg_Write_W, 1);

    // Asynchronous reset in the middle of an access.
    set_m(1, 0, 1, 1, 32'h300, 32'h0, 5'd4);
    tick();
    check("mr_req_before", dmem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_req", dmem_req, 0);
    check("mr_stall", stall_M, 0);
    check("mr_rdw", Read_Data_W, 0);
    check("mr_alu", ALU_Result_W, 0);
    check("mr_wreg", Write_Reg_W, 0);
    @(negedge clk);
    set_m(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0BAD_0BAD;
    tick();
    dmem_ack = 1'b0;
    check("mr_late_ack_req", dmem_req, 0);
    check("mr_late_ack_rdw", Read_Data_W, 0);
    check("mr_late_ack_stall", stall_M, 0);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned load is rejected without a memory request.
    set_m(1, 0, 1, 1, 32'h102, 32'h0, 5'd6);
    #1;
    check("mis_flag", misalign_M, 1);
    check("mis_stall", stall_M, 0);
    tick();
    check("mis_req", dmem_req, 0);
    check("mis_regw", Reg_Write_W, 0);
    check("mis_alu", ALU_Result_W, 32'h102);
    set_m(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
